// File: rtl/hpdcache_mshr_tgt.sv
// HPDcache MSHR: sets x ways of in-flight misses, each merging up to TGTS targets.
// Optional HPDCACHE_MSHR_PERF_EN adds alloc/merge pulses and a stall counter.
module hpdcache_mshr_tgt #(
    parameter int unsigned SETS    = 4,
    parameter int unsigned WAYS    = 4,
    parameter int unsigned TGTS    = 4,
    parameter int unsigned NLINE_W = 34,
    parameter int unsigned TID_W   = 6,
    parameter int unsigned SID_W   = 3,
    parameter int unsigned WORD_W  = 3,
    localparam int unsigned SET_W  = (SETS > 1) ? $clog2(SETS) : 1,
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               empty_o,
    output logic               full_o,
    input  logic [NLINE_W-1:0] check_nline_i,
    output logic               hit_o,
    output logic               tgt_full_o,
    output logic               alloc_ready_o,
    input  logic               alloc_i,
    input  logic [TID_W-1:0]   alloc_req_id_i,
    input  logic [SID_W-1:0]   alloc_src_id_i,
    input  logic [WORD_W-1:0]  alloc_word_i,
    input  logic               alloc_need_rsp_i,
    input  logic               alloc_is_prefetch_i,
    output logic [WAY_W-1:0]   alloc_way_o,
    output logic               alloc_merged_o,
    input  logic               ack_i,
    input  logic [SET_W-1:0]   ack_set_i,
    input  logic [WAY_W-1:0]   ack_way_i,
    output logic               ack_ready_o,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [NLINE_W-1:0] rsp_nline_o,
    output logic [TID_W-1:0]   rsp_req_id_o,
    output logic [SID_W-1:0]   rsp_src_id_o,
    output logic [WORD_W-1:0]  rsp_word_o,
    output logic               rsp_need_rsp_o,
    output logic               rsp_is_prefetch_o,
    output logic               rsp_last_o
`ifdef HPDCACHE_MSHR_PERF_EN
    ,
    output logic               perf_alloc_o,
    output logic               perf_merge_o,
    output logic [31:0]        perf_stall_cnt_o
`endif
);

    localparam int unsigned CNT_W = $clog2(TGTS + 1);
    localparam int unsigned IDX_W = (TGTS > 1) ? $clog2(TGTS) : 1;

    typedef struct packed {
        logic [TID_W-1:0]  tid;
        logic [SID_W-1:0]  sid;
        logic [WORD_W-1:0] word;
        logic              need_rsp;
        logic              is_pf;
    } tgt_t;

    typedef enum logic {IDLE, DRAIN} state_e;

    logic [SETS-1:0][WAYS-1:0] valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0] drain_q, drain_d;
    logic [NLINE_W-1:0]        nline_q [SETS][WAYS];
    logic [NLINE_W-1:0]        nline_d [SETS][WAYS];
    tgt_t                      tgt_q [SETS][WAYS][TGTS];
    tgt_t                      tgt_d [SETS][WAYS][TGTS];
    logic [CNT_W-1:0]          cnt_q [SETS][WAYS];
    logic [CNT_W-1:0]          cnt_d [SETS][WAYS];
    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [SET_W-1:0]          dset_q, dset_d;
    logic [WAY_W-1:0]          dway_q, dway_d;

    logic [SET_W-1:0] chk_set;
    logic             hit;
    logic             free_found;
    logic [WAY_W-1:0] hit_way;
    logic [WAY_W-1:0] free_way;
    logic [CNT_W-1:0] hit_cnt;
    tgt_t             alloc_tgt;
    tgt_t             rsp_tgt;
    logic             ack_acc;
    logic             rsp_last;
    logic             rsp_fire;

    assign chk_set = (SETS > 1) ? check_nline_i[SET_W-1:0] : '0;

    // Draining entries are still valid (not free) but never hit.
    always_comb begin
        hit        = 1'b0;
        hit_way    = '0;
        free_found = 1'b0;
        free_way   = '0;
        for (int w = int'(WAYS) - 1; w >= 0; w--) begin
            if (valid_q[chk_set][w] && !drain_q[chk_set][w] &&
                nline_q[chk_set][w] == check_nline_i) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[chk_set][w]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(w);
            end
        end
    end

    assign hit_cnt        = cnt_q[chk_set][hit_way];
    assign hit_o          = hit;
    assign tgt_full_o     = hit && (hit_cnt == CNT_W'(TGTS));
    assign alloc_merged_o = hit && !tgt_full_o;
    assign alloc_ready_o  = alloc_merged_o || (!hit && free_found);
    assign alloc_way_o    = hit ? hit_way : free_way;
    assign empty_o        = ~|valid_q;
    assign full_o         = &valid_q;

    assign alloc_tgt = '{alloc_req_id_i, alloc_src_id_i, alloc_word_i,
                         alloc_need_rsp_i, alloc_is_prefetch_i};

    assign rsp_tgt  = tgt_q[dset_q][dway_q][idx_q];
    assign rsp_last = (CNT_W'(idx_q) + CNT_W'(1)) == cnt_q[dset_q][dway_q];
    assign rsp_fire = rsp_valid_o && rsp_ready_i;
    assign ack_acc  = ack_i && ack_ready_o &&
                      valid_q[ack_set_i][ack_way_i] &&
                      !drain_q[ack_set_i][ack_way_i];

    assign ack_ready_o       = (state_q == IDLE);
    assign rsp_valid_o       = (state_q == DRAIN);
    assign rsp_nline_o       = nline_q[dset_q][dway_q];
    assign rsp_req_id_o      = rsp_tgt.tid;
    assign rsp_src_id_o      = rsp_tgt.sid;
    assign rsp_word_o        = rsp_tgt.word;
    assign rsp_need_rsp_o    = rsp_tgt.need_rsp;
    assign rsp_is_prefetch_o = rsp_tgt.is_pf;
    assign rsp_last_o        = rsp_last;

    always_comb begin
        valid_d = valid_q;
        drain_d = drain_q;
        nline_d = nline_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        idx_d   = idx_q;
        dset_d  = dset_q;
        dway_d  = dway_q;

        if (alloc_i && alloc_ready_o) begin
            if (alloc_merged_o) begin
                tgt_d[chk_set][alloc_way_o][IDX_W'(hit_cnt)] = alloc_tgt;
                cnt_d[chk_set][alloc_way_o] = hit_cnt + CNT_W'(1);
            end else begin
                valid_d[chk_set][alloc_way_o] = 1'b1;
                nline_d[chk_set][alloc_way_o] = check_nline_i;
                tgt_d[chk_set][alloc_way_o][0] = alloc_tgt;
                cnt_d[chk_set][alloc_way_o] = CNT_W'(1);
            end
        end

        if (rsp_fire) begin
            if (rsp_last) begin
                valid_d[dset_q][dway_q] = 1'b0;
                drain_d[dset_q][dway_q] = 1'b0;
                cnt_d[dset_q][dway_q]   = '0;
                state_d = IDLE;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end

        if (ack_acc) begin
            drain_d[ack_set_i][ack_way_i] = 1'b1;
            state_d = DRAIN;
            idx_d   = '0;
            dset_d  = ack_set_i;
            dway_d  = ack_way_i;
        end
    end

    always_ff @(posedge clk_i) begin
        nline_q <= nline_d;
        tgt_q   <= tgt_d;
        if (rst_i) begin
            valid_q <= '0;
            drain_q <= '0;
            cnt_q   <= '{default: '0};
            state_q <= IDLE;
            idx_q   <= '0;
            dset_q  <= '0;
            dway_q  <= '0;
        end else begin
            valid_q <= valid_d;
            drain_q <= drain_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            dset_q  <= dset_d;
            dway_q  <= dway_d;
        end
    end

`ifdef HPDCACHE_MSHR_PERF_EN
    logic        perf_alloc_q, perf_alloc_d;
    logic        perf_merge_q, perf_merge_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        perf_alloc_d = alloc_i && alloc_ready_o && !alloc_merged_o;
        perf_merge_d = alloc_i && alloc_merged_o;
        stall_cnt_d  = stall_cnt_q;
        if (alloc_i && !alloc_ready_o && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_alloc_q <= 1'b0;
            perf_merge_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            perf_alloc_q <= perf_alloc_d;
            perf_merge_q <= perf_merge_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign perf_alloc_o     = perf_alloc_q;
    assign perf_merge_o     = perf_merge_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

`ifndef SYNTHESIS
    a_alloc_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        alloc_i |-> alloc_ready_o);
    a_ack_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        (ack_i && ack_ready_o) |->
        (valid_q[ack_set_i][ack_way_i] && !drain_q[ack_set_i][ack_way_i]));
`endif

endmodule
